// File: rtl/mc_cu.sv
// -----------------------------------------------------------------------------
// mc_cu : multicycle control unit for the MIPS-subset processor.
//
// Sequences a shared-ALU, single-memory datapath through IF/ID/EXE/MEM/WB.
// Only the state register is sequential; every other output is a Mealy
// function of (state, op, func, z).
//
// Optional feature macro: MC_CU_ILLEGAL_TRAP_EN
//   defined   : an illegal op/func in ID enters HALT (state 5) until reset.
//   undefined : an illegal op/func retires as a 2-cycle NOP; HALT unused.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   op        in   IR[31:26]
//   func      in   IR[5:0]
//   z         in   ALU zero flag (combinational from datapath)
//   wpc       out  PC write enable
//   wir       out  IR write enable
//   iord      out  memory address select: 0=PC, 1=ALU result register
//   wmem      out  memory write enable
//   wreg      out  register file write enable
//   regrt     out  destination select: 1=rt, 0=rd
//   m2reg     out  write-back source: 1=MDR, 0=ALU result register
//   jal       out  write PC to register RA_REG
//   sext      out  immediate sign-extend (1) / zero-extend (0)
//   shift     out  ALU operand A = sa field
//   alusrca   out  ALU operand A: 0=PC, 1=rs (or sa when shift=1)
//   alusrcb   out  ALU operand B: 00=rt, 01=PC_INC, 10=imm, 11=imm<<2
//   aluc      out  ALU operation code
//   pcsource  out  PC source: 00=ALU, 01=target reg, 10=rs, 11=jump addr
//   state     out  current state: IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5
//   retire    out  one-cycle pulse on the last cycle of each instruction
// -----------------------------------------------------------------------------
module mc_cu #(
    parameter int PC_INC = 4,
    parameter int RA_REG = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic       wpc,
    output logic       wir,
    output logic       iord,
    output logic       wmem,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state,
    output logic       retire
);

    // The datapath hardwires the +4 incrementer and r31; these parameters are
    // informational and other values have no effect on the control outputs.
    if (PC_INC != 4 || RA_REG != 31) begin : g_param_informational
    end

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    state_t r_state;
    state_t w_next;

    // ---------------- instruction decode ----------------
    logic w_rtype;
    logic w_add, w_sub, w_and, w_or, w_xor, w_sll, w_srl, w_sra, w_jr;
    logic w_addi, w_andi, w_ori, w_xori, w_lui;
    logic w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
    logic w_r_alu, w_r_shift, w_i_alu, w_legal;

    assign w_rtype = (op == 6'b000000);
    assign w_add   = w_rtype && (func == 6'b100000);
    assign w_sub   = w_rtype && (func == 6'b100010);
    assign w_and   = w_rtype && (func == 6'b100100);
    assign w_or    = w_rtype && (func == 6'b100101);
    assign w_xor   = w_rtype && (func == 6'b100110);
    assign w_sll   = w_rtype && (func == 6'b000000);
    assign w_srl   = w_rtype && (func == 6'b000010);
    assign w_sra   = w_rtype && (func == 6'b000011);
    assign w_jr    = w_rtype && (func == 6'b001000);
    assign w_addi  = (op == 6'b001000);
    assign w_andi  = (op == 6'b001100);
    assign w_ori   = (op == 6'b001101);
    assign w_xori  = (op == 6'b001110);
    assign w_lui   = (op == 6'b001111);
    assign w_lw    = (op == 6'b100011);
    assign w_sw    = (op == 6'b101011);
    assign w_beq   = (op == 6'b000100);
    assign w_bne   = (op == 6'b000101);
    assign w_j     = (op == 6'b000010);
    assign w_jal   = (op == 6'b000011);

    assign w_r_alu   = w_add | w_sub | w_and | w_or | w_xor;
    assign w_r_shift = w_sll | w_srl | w_sra;
    assign w_i_alu   = w_addi | w_andi | w_ori | w_xori | w_lui;
    assign w_legal   = w_r_alu | w_r_shift | w_jr | w_i_alu | w_lw | w_sw |
                       w_beq | w_bne | w_j | w_jal;

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

    // ---------------- Mealy outputs and next state ----------------
    always_comb begin
        wpc      = 1'b0;
        wir      = 1'b0;
        iord     = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = ALU_ADD;
        pcsource = 2'b00;
        retire   = 1'b0;
        w_next   = S_IF;

        case (r_state)
            S_IF: begin
                // PC <= PC + PC_INC while the IR captures the fetched word.
                wir     = 1'b1;
                wpc     = 1'b1;
                alusrcb = 2'b01;
                w_next  = S_ID;
            end

            S_ID: begin
                if (w_j || w_jal) begin
                    pcsource = 2'b11;
                    wpc      = 1'b1;
                    retire   = 1'b1;
                    jal      = w_jal;
                    wreg     = w_jal;
                end else if (w_jr) begin
                    pcsource = 2'b10;
                    wpc      = 1'b1;
                    retire   = 1'b1;
                end else if (w_legal) begin
                    // Speculatively compute the branch target PC + (imm<<2).
                    alusrcb = 2'b11;
                    sext    = 1'b1;
                    w_next  = S_EXE;
                end else begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
                    w_next = S_HALT;
`else
                    retire = 1'b1;
`endif
                end
            end

            S_EXE: begin
                if (w_beq || w_bne) begin
                    alusrca  = 1'b1;
                    aluc     = ALU_SUB;
                    pcsource = 2'b01;
                    wpc      = w_beq ? z : ~z;
                    retire   = 1'b1;
                end else if (w_lw || w_sw) begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    sext    = 1'b1;
                    w_next  = S_MEM;
                end else if (w_r_alu || w_r_shift) begin
                    alusrca = 1'b1;
                    shift   = w_r_shift;
                    w_next  = S_WB;
                    if (w_sub)      aluc = ALU_SUB;
                    else if (w_and) aluc = ALU_AND;
                    else if (w_or)  aluc = ALU_OR;
                    else if (w_xor) aluc = ALU_XOR;
                    else if (w_sll) aluc = ALU_SLL;
                    else if (w_srl) aluc = ALU_SRL;
                    else if (w_sra) aluc = ALU_SRA;
                    else            aluc = ALU_ADD;
                end else if (w_i_alu) begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    sext    = w_addi;
                    w_next  = S_WB;
                    if (w_andi)      aluc = ALU_AND;
                    else if (w_ori)  aluc = ALU_OR;
                    else if (w_xori) aluc = ALU_XOR;
                    else if (w_lui)  aluc = ALU_LUI;
                    else             aluc = ALU_ADD;
                end
            end

            S_MEM: begin
                iord = 1'b1;
                if (w_sw) begin
                    wmem   = 1'b1;
                    retire = 1'b1;
                end else if (w_lw) begin
                    w_next = S_WB;
                end
            end

            S_WB: begin
                wreg   = 1'b1;
                retire = 1'b1;
                regrt  = ~w_rtype;
                m2reg  = w_lw;
            end

`ifdef MC_CU_ILLEGAL_TRAP_EN
            S_HALT: begin
                w_next = S_HALT;
            end
`endif

            default: begin
                w_next = S_IF;
            end
        endcase

        // Reset suppresses every write so an abandoned instruction has no
        // side effects in the cycle reset is seen.
        if (reset) begin
            wpc    = 1'b0;
            wir    = 1'b0;
            wmem   = 1'b0;
            wreg   = 1'b0;
            retire = 1'b0;
        end
    end

endmodule
